// File: rtl/alu_input_seq_if.sv
// Button/switch inputs and captured operand/opcode outputs of the ALU input sequencer.
// master drives buttons and switches; slave (the sequencer) drives the captured values and strobes.
interface alu_input_seq_if;
    logic        btn_a;
    logic        btn_b;
    logic        btn_f;
    logic [31:0] SW;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [3:0]  op_out;
    logic        exec_pulse;
    logic [1:0]  state;
    logic        ignored_pulse;

    modport master (
        output btn_a, btn_b, btn_f, SW,
        input  a_out, b_out, op_out, exec_pulse, state, ignored_pulse
    );

    modport slave (
        input  btn_a, btn_b, btn_f, SW,
        output a_out, b_out, op_out, exec_pulse, state, ignored_pulse
    );
endinterface

// File: rtl/alu_input_seq.sv
// Sync/debounce three buttons, capture A, B, opcode in order, then strobe exec for one cycle.
// Latency: raw rise before edge E0 -> capture visible after E0+DB_CYCLES+3.
// Backpressure: none; presses arriving in the wrong state are dropped and flagged on ignored_pulse.
module alu_input_seq #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    alu_input_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_A  = 2'd1,
        HAVE_AB = 2'd2,
        EXEC    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Bit 0 = A, bit 1 = B, bit 2 = F throughout.
    logic [2:0]       btn_raw;
    logic [2:0]       s1, s2, db, db_d, press;
    logic [CNT_W-1:0] cnt [3];

    state_t      st_q, st_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        ign_q, ign_d;

    logic win_a, win_b, win_f, lost;

    assign btn_raw = {bus.btn_f, bus.btn_b, bus.btn_a};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            db_d  <= db;
            press <= db & ~db_d;
            // Any return to the accepted level restarts the stability count.
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Fixed priority A > B > F; any losing press in the same cycle is reported.
    assign win_a = press[0];
    assign win_b = press[1] & ~press[0];
    assign win_f = press[2] & ~press[1] & ~press[0];
    assign lost  = (press[0] & (press[1] | press[2])) | (press[1] & press[2]);

    always_comb begin
        st_d  = st_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        ign_d = lost;
        case (st_q)
            IDLE: begin
                if (win_a) begin
                    a_d  = bus.SW;
                    st_d = HAVE_A;
                end else if (win_b || win_f) begin
                    ign_d = 1'b1;
                end
            end
            HAVE_A: begin
                if (win_a) begin
                    a_d = bus.SW;
                end else if (win_b) begin
                    b_d  = bus.SW;
                    st_d = HAVE_AB;
                end else if (win_f) begin
                    ign_d = 1'b1;
                end
            end
            HAVE_AB: begin
                if (win_a) begin
                    a_d  = bus.SW;
                    st_d = HAVE_A;
                end else if (win_b) begin
                    b_d = bus.SW;
                end else if (win_f) begin
                    op_d = bus.SW[3:0];
                    st_d = EXEC;
                end
            end
            EXEC: begin
                // Single-cycle state; A/B behave as in HAVE_AB, F cannot re-enter EXEC back to back.
                st_d = HAVE_AB;
                if (win_a) begin
                    a_d  = bus.SW;
                    st_d = HAVE_A;
                end else if (win_b) begin
                    b_d = bus.SW;
                end else if (win_f) begin
                    ign_d = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            ign_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            ign_q <= ign_d;
        end
    end

    assign bus.a_out         = a_q;
    assign bus.b_out         = b_q;
    assign bus.op_out        = op_q;
    assign bus.exec_pulse    = (st_q == EXEC);
    assign bus.state         = st_q;
    assign bus.ignored_pulse = ign_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// Randomised and directed button sequences checked against a press-level model through a timed scoreboard.
module tb_alu_input_seq;

    localparam int DB  = 4;
    // Stimulus applied at the falling edge counted k becomes visible at the falling edge counted k+LAT.
    localparam int LAT = DB + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_input_seq_if bus ();

    alu_input_seq #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [1:0]  st;
        logic        ex;
        logic        ig;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   final_chk = 1'b0;

    // Reference model: operand registers and sequencing position as the spec's table describes them.
    int          m_st;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void push_exp(input int when, input logic [1:0] st, input logic ex, input logic ig);
        exp_t e;
        e.cyc = when; e.a = m_a; e.b = m_b; e.op = m_op; e.st = st; e.ex = ex; e.ig = ig;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_st = 0; m_a = '0; m_b = '0; m_op = '0;
    endfunction

    function automatic void model_press(input logic [2:0] m, input logic [31:0] sw, input int k);
        int          win;
        bit          lost;
        bit          rej;
        logic [31:0] oa, ob;
        int          ost;
        int          when;
        when = k + LAT;
        lost = ($countones(m) > 1);
        rej  = 1'b0;
        oa = m_a; ob = m_b; ost = m_st;
        if (m[0])      win = 0;
        else if (m[1]) win = 1;
        else if (m[2]) win = 2;
        else return;
        case (m_st)
            0: if (win == 0) begin m_a = sw; m_st = 1; end
               else rej = 1'b1;
            1: if (win == 0) m_a = sw;
               else if (win == 1) begin m_b = sw; m_st = 2; end
               else rej = 1'b1;
            default: begin
                if (win == 0) begin m_a = sw; m_st = 1; end
                else if (win == 1) m_b = sw;
                else begin
                    m_op = sw[3:0];
                    push_exp(when, 2'd3, 1'b1, lost);
                    push_exp(when + 1, 2'd2, 1'b0, 1'b0);
                    m_st = 2;
                    return;
                end
            end
        endcase
        if (lost || rej || oa != m_a || ob != m_b || ost != m_st)
            push_exp(when, 2'(m_st), 1'b0, lost || rej);
    endfunction

    // Monitor: every visible output change or strobe must match the head of the scoreboard.
    initial begin
        logic [31:0] pa, pb;
        logic [3:0]  pop;
        logic [1:0]  pst;
        logic        pex;
        bit          ev;
        bit          final_done;
        exp_t        e;
        pa = '0; pb = '0; pop = '0; pst = '0; pex = 1'b0; final_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tests++;
                if (bus.a_out != 0 || bus.b_out != 0 || bus.op_out != 0 || bus.state != 0 ||
                    bus.exec_pulse || bus.ignored_pulse) begin
                    fails++;
                    $display("FAIL reset_state cyc=%0d: got a=%h b=%h op=%h st=%0d ex=%b ig=%b, want all zero",
                             cyc, bus.a_out, bus.b_out, bus.op_out, bus.state, bus.exec_pulse, bus.ignored_pulse);
                end
                pa = '0; pb = '0; pop = '0; pst = '0; pex = 1'b0;
            end else begin
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    tests++;
                    fails++;
                    e = q.pop_front();
                    $display("FAIL missing_event: nothing seen at cyc=%0d, want a=%h b=%h op=%h st=%0d ex=%b ig=%b",
                             e.cyc, e.a, e.b, e.op, e.st, e.ex, e.ig);
                end
                if (bus.exec_pulse) begin
                    tests++;
                    if (pex) begin
                        fails++;
                        $display("FAIL exec_back_to_back cyc=%0d: exec_pulse high twice, want single cycle", cyc);
                    end
                end
                ev = (bus.a_out != pa) || (bus.b_out != pb) || (bus.op_out != pop) ||
                     (bus.state != pst) || bus.exec_pulse || bus.ignored_pulse;
                if (ev) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event cyc=%0d: got a=%h b=%h op=%h st=%0d ex=%b ig=%b, want no change",
                                 cyc, bus.a_out, bus.b_out, bus.op_out, bus.state, bus.exec_pulse, bus.ignored_pulse);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || e.a != bus.a_out || e.b != bus.b_out || e.op != bus.op_out ||
                            e.st != bus.state || e.ex != bus.exec_pulse || e.ig != bus.ignored_pulse) begin
                            fails++;
                            $display("FAIL event: got cyc=%0d a=%h b=%h op=%h st=%0d ex=%b ig=%b, want cyc=%0d a=%h b=%h op=%h st=%0d ex=%b ig=%b",
                                     cyc, bus.a_out, bus.b_out, bus.op_out, bus.state, bus.exec_pulse, bus.ignored_pulse,
                                     e.cyc, e.a, e.b, e.op, e.st, e.ex, e.ig);
                        end
                    end
                end
                if (final_chk && !final_done) begin
                    final_done = 1'b1;
                    tests++;
                    if (q.size() != 0) begin
                        fails++;
                        $display("FAIL pending_events: %0d expected events never seen, want 0", q.size());
                    end
                end
                pa = bus.a_out; pb = bus.b_out; pop = bus.op_out; pst = bus.state; pex = bus.exec_pulse;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic press(input logic [2:0] m, input logic [31:0] sw);
        bus.SW = sw;
        {bus.btn_f, bus.btn_b, bus.btn_a} = m;
        model_press(m, sw, cyc);
        tick(DB + 6);
        {bus.btn_f, bus.btn_b, bus.btn_a} = 3'b000;
        repeat (DB + 6) begin
            tick(1);
            bus.SW = $urandom;
        end
    endtask

    initial begin
        logic [2:0]  combos [7];
        logic [31:0] v;
        combos = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};
        bus.btn_a = 1'b0; bus.btn_b = 1'b0; bus.btn_f = 1'b0; bus.SW = '0;
        model_reset();
        tick(3);
        rst = 1'b0;

        // First capture latency, then a complete A/B/F sequence.
        press(3'b001, 32'h0000_0005);
        press(3'b001, 32'h1234_5678);
        press(3'b010, 32'h0000_0003);
        press(3'b100, 32'h0000_0002);

        // Out-of-order presses from IDLE are rejected.
        do_reset();
        press(3'b100, $urandom);
        press(3'b010, $urandom);

        // Simultaneous A and B while holding both operands.
        press(3'b001, $urandom);
        press(3'b010, $urandom);
        press(3'b011, $urandom);

        // Bouncing rise settles into a single capture.
        v = $urandom;
        bus.SW = v;
        bus.btn_a = 1'b1; tick(2);
        bus.btn_a = 1'b0; tick(2);
        bus.btn_a = 1'b1; tick(2);
        bus.btn_a = 1'b0; tick(2);
        bus.btn_a = 1'b1;
        model_press(3'b001, v, cyc);
        tick(10);
        bus.btn_a = 1'b0;
        tick(DB + 6);

        // Three-cycle glitch is filtered.
        bus.btn_b = 1'b1; tick(3);
        bus.btn_b = 1'b0; tick(DB + 6);

        // Reset while a held button is mid-debounce; it is accepted again after release of reset.
        v = $urandom;
        bus.SW = v;
        bus.btn_a = 1'b1;
        tick(4);
        rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0;
        model_press(3'b001, v, cyc);
        tick(DB + 8);
        bus.btn_a = 1'b0;
        tick(DB + 6);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 11) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) press(combos[$urandom_range(0, 2)], $urandom);
            else press(combos[$urandom_range(0, 6)], $urandom);
        end

        tick(LAT + 2);
        final_chk = 1'b1;
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_input_seq.md
Name: alu_input_seq

Overview:
Upstream operand/command sequencer for the ALU datapath. It takes the three raw push-buttons (A-load, B-load, execute) and the 32-bit switch bank, and synchronises and debounces the buttons on one system clock. A state machine captures operand A, operand B and the 4-bit opcode in that order. It then issues a single-cycle exec strobe, which the ALU result/flag register uses as its load enable, so no button is used as a clock.

Parameters:
DB_CYCLES, 1000000, consecutive stable synchronised cycles required before a button level change is accepted (min 2)
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DB_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
btn_a  input  1  raw asynchronous button, load operand A
btn_b  input  1  raw asynchronous button, load operand B
btn_f  input  1  raw asynchronous button, execute
SW  input  32  switch bank; operand source, SW[3:0] also opcode source
a_out  output  32  captured operand A
b_out  output  32  captured operand B
op_out  output  4  captured opcode
exec_pulse  output  1  one-cycle strobe, operands and opcode valid
state  output  2  FSM state: 0 IDLE, 1 HAVE_A, 2 HAVE_AB, 3 EXEC
ignored_pulse  output  1  one-cycle strobe, a press was rejected

Behaviour:
- Reset (rst high at an edge): a_out=0, b_out=0, op_out=0, exec_pulse=0, ignored_pulse=0, state=IDLE.
  - Reset also clears all sync flops, debounced levels, delayed levels, counters and press pulses.
  - Reset mid-debounce or mid-EXEC aborts with no strobe.
- Per button, 2-FF synchroniser s1 -> s2. SW is sampled directly and is quasi-static.
- Debounce counter, per button:
  - if s2 == db: cnt <= 0
  - else if cnt == DB_CYCLES-1: db <= s2, cnt <= 0
  - else: cnt <= cnt+1
  - Any bounce back to db restarts the count. A pulse shorter than DB_CYCLES synchronised cycles is filtered.
- Press detect: db_d <= db; press <= db & ~db_d (registered, exactly one cycle per accepted rising level). Release generates nothing.
- A button held through reset deasserts its level at reset. It yields exactly one press DB_CYCLES+2 edges after rst falls.
- Latency: raw rise stable before edge E0 -> press high after edge E0+DB_CYCLES+2 -> capture visible after edge E0+DB_CYCLES+3.
- Simultaneous presses in one cycle: priority A > B > F. Lower-priority presses are discarded and raise ignored_pulse.
- FSM actions on the winning press (registered, take effect at the next edge):
  - IDLE:
    - A: a_out<=SW, -> HAVE_A
    - B or F: ignored_pulse, stay
  - HAVE_A:
    - A: a_out<=SW, stay
    - B: b_out<=SW, -> HAVE_AB
    - F: ignored_pulse, stay
  - HAVE_AB:
    - A: a_out<=SW, -> HAVE_A (B must be reloaded; b_out keeps its old value)
    - B: b_out<=SW, stay
    - F: op_out<=SW[3:0], -> EXEC
  - EXEC: lasts exactly one cycle. exec_pulse=1 is decoded from the state, with a_out/b_out/op_out stable.
    - Next state HAVE_AB, so repeated F presses re-execute the same operands with a new opcode.
    - A or B press during EXEC: handled as in HAVE_AB; B takes effect after EXEC.
- exec_pulse is high only in EXEC and never on two consecutive cycles. ignored_pulse is one cycle per rejected press cycle.
- Outputs hold between captures. SW changes never alter outputs without a press.

Test Plan:
- DB_CYCLES=4: rst; SW=0x0000_0005, clean btn_a rise before edge E0 -> a_out=0x5 and state=1 after edge E0+7; a_out unchanged at E0+6.
- Full sequence: A with SW=0x12345678, B with SW=0x0000_0003, F with SW=0x0000_0002 -> a_out=0x12345678, b_out=0x3, op_out=0x2; exec_pulse high exactly 1 cycle; state 2->3->2.
- Bounce: btn_a toggles 1,0,1,0 every 2 cycles then holds 1 for 10 cycles -> exactly one capture; glitch of 3 cycles alone -> no capture.
- Out-of-order: after rst, press btn_f, then btn_b -> two ignored_pulse strobes, state stays 0, exec_pulse never high, a_out/b_out remain 0.
- Simultaneous btn_a and btn_b rise in HAVE_AB -> A captured, state=1, ignored_pulse=1 for one cycle, b_out unchanged.
- Reset mid-debounce: btn_a high, rst asserted at count 2 while held -> all outputs 0; one press DB_CYCLES+2 edges after rst release, capture one edge later.
